// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// one-cycle VALID/FERR strobes and a held DOUT register.
module uart_rx #(
  parameter int unsigned Fclk = 50_000_000,
  parameter int unsigned Baud = 115_200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] DOUT,
  output logic       VALID,
  output logic       FERR,
  output logic       BUSY
);

  localparam int unsigned Div  = Fclk / Baud;
  localparam int unsigned Half = Div / 2;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      dout_q;
  logic            valid_q;
  logic            ferr_q;
  logic            busy_q;

  logic            rx_meta_q;
  logic            rx_sync_q;

  logic            half_done;
  logic            bit_done;

  // RXD is asynchronous; both flops reset to the idle (high) line level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RXD;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign half_done = (cnt_q == CntW'(Half - 1));
  assign bit_done  = (cnt_q == CntW'(Div - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_sync_q) begin
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (half_done) begin
            cnt_q <= '0;
            if (!rx_sync_q) begin
              idx_q   <= '0;
              state_q <= StData;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (bit_done) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_sync_q;
            if (idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (bit_done) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            // Re-arm at the stop-bit midpoint so back-to-back frames are not lost.
            if (rx_sync_q) begin
              dout_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= StIdle;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= StWaitIdle;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitIdle: begin
          // A held-low break must not restart reception until the line recovers.
          if (rx_sync_q) begin
            state_q <= StIdle;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign DOUT  = dout_q;
  assign VALID = valid_q;
  assign FERR  = ferr_q;
  assign BUSY  = busy_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      assert (!(valid_q && ferr_q))
        else $error("uart_rx: VALID and FERR asserted together");
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, back-to-back frames, glitch,
// framing error with break, mid-frame reset and a loopback transmitter.
module tb_uart_rx;

  localparam int unsigned Div = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drv_rxd = 1'b1;
  logic       tx_line = 1'b1;
  logic       loop_en = 1'b0;
  logic       rxd;
  logic [7:0] dout;
  logic       valid;
  logic       ferr;
  logic       busy;

  logic       oe = 1'b0;
  logic [7:0] din = 8'h00;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int overlap_cnt = 0;
  int wide_cnt = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr = 1'b0;

  assign rxd = loop_en ? tx_line : drv_rxd;

  uart_rx #(
    .Fclk(50_000_000),
    .Baud(115_200)
  ) dut (
    .CLK  (clk),
    .RST  (rst_n),
    .RXD  (rxd),
    .DOUT (dout),
    .VALID(valid),
    .FERR (ferr),
    .BUSY (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (valid && ferr) overlap_cnt <= overlap_cnt + 1;
    if ((valid && prev_valid) || (ferr && prev_ferr)) wide_cnt <= wide_cnt + 1;
    prev_valid <= valid;
    prev_ferr  <= ferr;
  end

  // Stand-in for the team transmitter: on OE, shift out start, DIN LSB first, stop.
  initial begin
    logic [9:0] frame;
    forever begin
      @(negedge clk);
      if (oe) begin
        frame = {1'b1, din, 1'b0};
        for (int b = 0; b < 10; b++) begin
          tx_line = frame[b];
          repeat (Div) @(negedge clk);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    @(negedge clk);
    drv_rxd   = 1'b0;
    start_cyc = cyc;
    repeat (Div) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      drv_rxd = data[b];
      repeat (Div) @(negedge clk);
    end
    drv_rxd = stop_bit;
    repeat (Div) @(negedge clk);
  endtask

  initial begin
    int v0;
    int f0;
    int lat;
    logic [7:0] part;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_dout", dout, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", ferr, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single 'U' frame, with latency from the start-bit falling edge
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b1);
    repeat (Div) @(negedge clk);
    check("u_valid_cnt", valid_cnt - v0, 1);
    check("u_dout", dout, 8'h55);
    check("u_ferr_cnt", ferr_cnt - f0, 0);
    lat = last_valid_cyc - start_cyc;
    check("u_latency_4126pm1", (lat >= 4125 && lat <= 4127), 1'b1);

    // Back-to-back frames with no idle time between them
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b1);
    check("b2b_first_cnt", valid_cnt - v0, 1);
    check("b2b_first_dout", dout, 8'hA5);
    send_frame(8'h3C, 1'b1);
    repeat (Div) @(negedge clk);
    check("b2b_second_cnt", valid_cnt - v0, 2);
    check("b2b_second_dout", dout, 8'h3C);

    // 100-cycle glitch, shorter than half a bit
    v0 = valid_cnt;
    f0 = ferr_cnt;
    @(negedge clk);
    drv_rxd = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_high", busy, 1'b1);
    repeat (90) @(negedge clk);
    drv_rxd = 1'b1;
    repeat (2 * Div) @(negedge clk);
    check("glitch_valid_cnt", valid_cnt - v0, 0);
    check("glitch_ferr_cnt", ferr_cnt - f0, 0);
    check("glitch_busy_low", busy, 1'b0);
    check("glitch_dout", dout, 8'h3C);

    // Framing error followed by a 5000-cycle break, then a good frame
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'hFF, 1'b0);
    repeat (5000) @(negedge clk);
    check("ferr_cnt", ferr_cnt - f0, 1);
    check("ferr_valid_cnt", valid_cnt - v0, 0);
    check("ferr_dout_held", dout, 8'h3C);
    check("ferr_busy", busy, 1'b0);
    drv_rxd = 1'b1;
    repeat (Div) @(negedge clk);
    send_frame(8'h12, 1'b1);
    repeat (Div) @(negedge clk);
    check("after_break_valid_cnt", valid_cnt - v0, 1);
    check("after_break_dout", dout, 8'h12);
    check("after_break_ferr_cnt", ferr_cnt - f0, 1);

    // Reset asserted in the middle of data bit 4
    part = 8'hC3;
    @(negedge clk);
    drv_rxd = 1'b0;
    repeat (Div) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      drv_rxd = part[b];
      repeat (Div) @(negedge clk);
    end
    drv_rxd = part[4];
    repeat (Div / 2) @(negedge clk);
    check("midrst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_dout", dout, 8'h00);
    check("midrst_valid", valid, 1'b0);
    check("midrst_ferr", ferr, 1'b0);
    check("midrst_busy", busy, 1'b0);
    drv_rxd = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    v0 = valid_cnt;
    send_frame(8'h81, 1'b1);
    repeat (Div) @(negedge clk);
    check("post_rst_valid_cnt", valid_cnt - v0, 1);
    check("post_rst_dout", dout, 8'h81);

    // Loopback from the transmitter model
    loop_en = 1'b1;
    repeat (Div) @(negedge clk);
    v0  = valid_cnt;
    din = 8'h55;
    oe  = 1'b1;
    @(negedge clk);
    oe  = 1'b0;
    repeat (11 * Div) @(negedge clk);
    check("loop_valid_cnt", valid_cnt - v0, 1);
    check("loop_dout", dout, 8'h55);
    loop_en = 1'b0;

    // Strobe shape over the whole run
    check("valid_ferr_overlap", overlap_cnt, 0);
    check("strobe_wider_than_1", wide_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
